// File: rtl/uart_cmd_parser.sv
// Monitor command decoder: turns received UART bytes into command codes and hex arguments.
// state | meaning: IDLE wait for letter; ARG collect numbered args; STREAM data words until ^C; RUN command executing
module uart_cmd_parser #(
  parameter int DATA_W    = 32,
  parameter bit FIXED_LEN = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_en,
  input  logic              i_busy,
  output logic [3:0]        o_cmd_code,
  output logic              o_cmd_start,
  output logic              o_arg_valid,
  output logic [1:0]        o_arg_idx,
  output logic [DATA_W-1:0] o_arg_data,
  output logic              o_go,
  output logic              o_quit,
  output logic              o_crlf_req,
  output logic              o_err
);

  localparam int MAXD = DATA_W / 4;
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARG    = 2'd1,
    S_STREAM = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_byte;
  logic              r_byte_v;
  logic [DATA_W-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_idx;
  logic              r_busy_seen;
  logic              r_go_arm;

  logic              w_is_hex;
  logic [3:0]        w_nibble;
  logic              w_is_bs;
  logic              w_is_term;
  logic              w_is_quit;
  logic [3:0]        w_letter;
  logic              w_in_arg;
  logic              w_full;
  logic              w_fixed_done;
  logic              w_term_done;
  logic              w_complete;
  logic              w_last;
  logic              w_busy_cmd;
  logic [DATA_W-1:0] w_acc_shl;
  logic [DATA_W-1:0] w_word;

  always_comb begin
    w_is_hex = 1'b1;
    w_nibble = 4'h0;
    if (r_byte >= 8'h30 && r_byte <= 8'h39)
      w_nibble = r_byte[3:0];
    else if ((r_byte >= 8'h61 && r_byte <= 8'h66) || (r_byte >= 8'h41 && r_byte <= 8'h46))
      w_nibble = r_byte[3:0] + 4'd9;
    else
      w_is_hex = 1'b0;
  end

  always_comb begin
    case (r_byte)
      8'h67:   w_letter = 4'd1;
      8'h77:   w_letter = 4'd2;
      8'h72:   w_letter = 4'd3;
      8'h74:   w_letter = 4'd4;
      8'h73:   w_letter = 4'd5;
      8'h70:   w_letter = 4'd6;
      8'h69:   w_letter = 4'd7;
      8'h6A:   w_letter = 4'd8;
      8'h7A:   w_letter = 4'd9;
      default: w_letter = 4'd0;
    endcase
  end

  always_comb begin
    w_is_bs      = (r_byte == 8'h08) || (r_byte == 8'h7F);
    w_is_term    = (r_byte == 8'h20) || (r_byte == 8'h0D);
    w_is_quit    = (r_byte == 8'h03);
    w_in_arg     = (r_state == S_ARG) || (r_state == S_STREAM);
    w_full       = (r_cnt == CW'(MAXD));
    w_acc_shl    = {r_acc[DATA_W-5:0], w_nibble};
    // Fixed-length words finish on the last digit itself, using the value being shifted in.
    w_fixed_done = FIXED_LEN && r_byte_v && w_in_arg && w_is_hex && (r_cnt == CW'(MAXD - 1));
    w_term_done  = !FIXED_LEN && r_byte_v && w_in_arg && w_is_term && (r_cnt != '0);
    w_complete   = w_fixed_done || w_term_done;
    w_word       = w_fixed_done ? w_acc_shl : r_acc;
    w_last       = (r_idx == 2'd1) || (o_cmd_code == 4'd1) || (o_cmd_code == 4'd2) ||
                   (o_cmd_code == 4'd7);
    w_busy_cmd   = (o_cmd_code == 4'd3) || (o_cmd_code == 4'd6) ||
                   (o_cmd_code == 4'd4) || (o_cmd_code == 4'd8);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_byte      <= '0;
      r_byte_v    <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_busy_seen <= 1'b0;
      r_go_arm    <= 1'b0;
      o_cmd_code  <= '0;
      o_cmd_start <= 1'b0;
      o_arg_valid <= 1'b0;
      o_arg_idx   <= '0;
      o_arg_data  <= '0;
      o_go        <= 1'b0;
      o_quit      <= 1'b0;
      o_crlf_req  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_cmd_start <= 1'b0;
      o_arg_valid <= 1'b0;
      o_quit      <= 1'b0;
      o_crlf_req  <= 1'b0;
      o_err       <= 1'b0;
      r_go_arm    <= 1'b0;
      o_go        <= r_go_arm;
      r_byte_v    <= i_rx_en;
      if (i_rx_en)
        r_byte <= i_rx_data;

      if (r_state == S_RUN && w_busy_cmd) begin
        if (i_busy)
          r_busy_seen <= 1'b1;
        else if (r_busy_seen)
          r_state <= S_IDLE;
      end

      if (r_byte_v) begin
        if (w_is_quit) begin
          o_quit      <= 1'b1;
          o_crlf_req  <= 1'b1;
          r_state     <= S_IDLE;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_idx       <= '0;
          r_busy_seen <= 1'b0;
          o_cmd_code  <= '0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_letter != 4'd0) begin
                o_cmd_start <= 1'b1;
                o_cmd_code  <= w_letter;
                r_idx       <= '0;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_busy_seen <= 1'b0;
                case (w_letter)
                  4'd1, 4'd2, 4'd3, 4'd6, 4'd7: r_state <= S_ARG;
                  4'd4, 4'd8, 4'd9: begin
                    r_state    <= S_RUN;
                    o_crlf_req <= 1'b1;
                  end
                  default: r_state <= S_IDLE;
                endcase
              end else if (r_byte == 8'h0D) begin
                o_crlf_req <= 1'b1;
              end
            end
            S_ARG, S_STREAM: begin
              if (w_complete) begin
                o_arg_valid <= 1'b1;
                o_arg_data  <= w_word;
                o_arg_idx   <= r_idx;
                r_acc       <= '0;
                r_cnt       <= '0;
                if (r_state == S_ARG) begin
                  if (w_last) begin
                    o_crlf_req <= 1'b1;
                    if (o_cmd_code == 4'd2 || o_cmd_code == 4'd7) begin
                      r_state <= S_STREAM;
                      r_idx   <= 2'd2;
                    end else begin
                      r_state     <= S_RUN;
                      r_busy_seen <= 1'b0;
                      r_go_arm    <= (o_cmd_code == 4'd1);
                    end
                  end else begin
                    r_idx <= r_idx + 2'd1;
                  end
                end
              end else if (w_is_hex) begin
                if (w_full) begin
                  o_err <= 1'b1;
                end else begin
                  r_acc <= w_acc_shl;
                  r_cnt <= r_cnt + CW'(1);
                end
              end else if (w_is_bs) begin
                if (r_cnt != '0) begin
                  r_acc <= r_acc >> 4;
                  r_cnt <= r_cnt - CW'(1);
                end
              end else if (!w_is_term) begin
                o_err <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule
